transpose_buffer: RTL and testbench
===================================

TRANSPOSE_BUFFER -- requirements
Module: transpose_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16: sample width in bits, two's complement, MSB is the sign bit.
REQ-002 SHALL have parameter N, default 8: block dimension; the block holds N x N samples.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_data, input, DATA_W bits: row-DCT coefficient, arriving in row-major order.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a sample this cycle.
REQ-008 SHALL have port out_data, output, DATA_W bits: transposed sample, leaving in column-major order, to feed the column-DCT adder stage.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream stage accepts out_data.
REQ-011 SHALL have port out_first, output, 1 bit: marks the first sample of an output block.
REQ-012 SHALL have port out_last, output, 1 bit: marks the last sample of an output block.

Function
REQ-013 SHALL hold two banks (bank 0 and bank 1) of N*N words each, plus one full flag per bank, a write bank select, a read bank select, a write index (0..N*N-1) and a read index (0..N*N-1).
REQ-014 SHALL accept an input sample only on a cycle where in_valid=1 and in_ready=1; data transfers only on that handshake.
REQ-015 SHALL store the k-th accepted sample of a block at bank[wr_bank][k]; k = row*N + col.
REQ-016 SHALL drive in_ready = NOT full[wr_bank], combinationally.
REQ-017 SHALL, on acceptance with write index = N*N-1, set full[wr_bank], toggle wr_bank and clear the write index.
REQ-018 SHALL drive out_valid = full[rd_bank], combinationally.
REQ-019 SHALL drive out_data, for read index j, as bank[rd_bank][(j mod N)*N + (j div N)]; the output is the exact transpose of the input, with no arithmetic, truncation or sign change.
REQ-020 SHALL advance the read index only on a cycle where out_valid=1 and out_ready=1.
REQ-021 SHALL drive out_first = out_valid AND (j = 0).
REQ-022 SHALL drive out_last = out_valid AND (j = N*N-1).
REQ-023 SHALL, on an output handshake with j = N*N-1, clear full[rd_bank], toggle rd_bank and clear the read index.
REQ-024 Latency: SHALL assert out_valid in the cycle immediately after the edge that accepts the N*N-th sample, provided that bank was empty of pending reads.
REQ-025 Simultaneous events: if one bank's final write and the other bank's final read handshake on the same edge, SHALL apply both updates independently; neither is lost or delayed.
REQ-026 SHALL deassert in_ready while both banks are full; samples presented then are not stored.
REQ-027 SHALL hold out_data, out_first and out_last stable while out_valid=1 and out_ready=0.
REQ-028 Throughput: with out_ready held at 1 and in_valid held at 1, SHALL sustain one sample per cycle in and out, with no bubbles after the first block.
REQ-029 Wrap-around: the write and read indices SHALL wrap from N*N-1 to 0; the bank selects SHALL alternate 0,1,0,1,...
REQ-030 SHALL NOT require the banks to be reset; bank contents are never visible while the corresponding full flag is 0.

Reset
REQ-031 While rst_n=0, asynchronously: full flags=0, wr_bank=0, rd_bank=0, both indices=0.
REQ-032 While rst_n=0, the outputs SHALL be out_valid=0, out_first=0, out_last=0 and in_ready=1.
REQ-033 Reset mid-block SHALL discard all partially written and unread data; after rst_n rises, the first accepted sample is row 0, col 0 of a new block in bank 0.

Verification
REQ-034 Single block: feed values 0..63 with out_ready=1 -> out_valid rises one cycle after the 64th accept; outputs are 0,8,16,...,56,1,9,...,63; out_first on 0; out_last on 63.
REQ-035 Signed pass-through: input 16'h8000 at (0,1) and 16'h7FFF at (1,0) -> outputs at j=8 and j=1 are 16'h8000 and 16'h7FFF unchanged.
REQ-036 Back-pressure: hold out_ready=0, stream 3 blocks -> in_ready falls after 128 accepts; the third block stalls; releasing out_ready drains block 1 then block 2 in order, with no loss.
REQ-037 Streaming: continuous valid/ready for 4 blocks -> 256 outputs, one per cycle, with no gap after the first out_valid; each block is correctly transposed.
REQ-038 Output stall: toggle out_ready randomly -> out_data is stable during every stall; the output sequence is identical to the REQ-034 order.
REQ-039 Reset mid-operation: assert rst_n=0 after 37 samples, then release and feed 64 new samples -> the output contains only the new block; no stale sample appears.

Source files
------------

// File: rtl/transpose_buffer.sv
// Ping-pong transpose buffer: rows in (row-major), columns out (column-major).
// Latency: out_valid rises the cycle after the edge that accepts the last sample of a block,
// provided the target bank is idle. Backpressure: in_ready drops while both banks are full.
// Ports: clk/rst_n; in_data/in_valid/in_ready upstream handshake;
//        out_data/out_valid/out_ready/out_first/out_last downstream handshake with block markers.
module transpose_buffer #(
  parameter int DATA_W = 16,
  parameter int N      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last
);
  localparam int DEPTH = N * N;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  // Sample storage; never reset, contents only observable behind a set full flag.
  logic [DATA_W-1:0] bank0_q [DEPTH];
  logic [DATA_W-1:0] bank1_q [DEPTH];

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;

  logic             wr_fire;
  logic             rd_fire;
  logic [IDX_W-1:0] rd_addr;

  // Read index j walks the column-major order; map it back to the row-major address.
  always_comb begin
    rd_addr = IDX_W'((int'(rd_idx_q) % N) * N + int'(rd_idx_q) / N);
  end

  always_comb begin
    in_ready  = ~full_q[wr_bank_q];
    out_valid = full_q[rd_bank_q];
    out_data  = rd_bank_q ? bank1_q[rd_addr] : bank0_q[rd_addr];
    out_first = out_valid && (rd_idx_q == '0);
    out_last  = out_valid && (rd_idx_q == LAST_IDX);
    wr_fire   = in_valid && in_ready;
    rd_fire   = out_valid && out_ready;
  end

  // A completing write and a completing read always target different banks
  // (one needs the bank empty, the other full), so both flag updates apply.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    if (wr_fire) begin
      if (wr_idx_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
    if (rd_fire) begin
      if (rd_idx_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_idx_d          = '0;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire && !wr_bank_q) bank0_q[wr_idx_q] <= in_data;
    if (wr_fire &&  wr_bank_q) bank1_q[wr_idx_q] <= in_data;
  end

endmodule

// File: tb/tb_transpose_buffer.sv
module tb_transpose_buffer;
  localparam int DATA_W = 16;
  localparam int N      = 8;
  localparam int NN     = N * N;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_first;
  logic              out_last;

  transpose_buffer #(.DATA_W(DATA_W), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_first(out_first),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  // Reference model: samples of the block being filled, and the queue of
  // transposed samples from completed blocks still waiting to be read.
  logic [DATA_W-1:0] cur_blk[$];
  logic [DATA_W-1:0] exp_q[$];
  int rd_cnt;
  int acc_cnt;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dut_acc;
  int dut_pops;
  int dut_first_cyc;
  int dut_last_cyc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: check outputs at the falling edge against the model, then drive
  // inputs for the next rising edge and advance the model by what that edge commits.
  task automatic cycle(input bit iv, input bit ordy, input logic [DATA_W-1:0] d);
    bit m_ready;
    bit m_valid;
    @(negedge clk);
    cyc++;
    m_ready = (exp_q.size() <= NN);
    m_valid = (exp_q.size() != 0);
    check_val("in_ready", 32'(in_ready), 32'(m_ready));
    check_val("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check_val("out_data", 32'(out_data), 32'(exp_q[0]));
      check_val("out_first", 32'(out_first), 32'(rd_cnt == 0));
      check_val("out_last", 32'(out_last), 32'(rd_cnt == NN - 1));
    end else begin
      check_val("out_first_idle", 32'(out_first), 32'd0);
      check_val("out_last_idle", 32'(out_last), 32'd0);
    end
    if (iv && in_ready) dut_acc++;
    if (ordy && out_valid) begin
      dut_pops++;
      if (dut_first_cyc < 0) dut_first_cyc = cyc;
      dut_last_cyc = cyc;
    end
    in_valid  = iv;
    out_ready = ordy;
    in_data   = d;
    if (iv && m_ready) begin
      cur_blk.push_back(d);
      acc_cnt++;
      if (cur_blk.size() == NN) begin
        for (int j = 0; j < NN; j++) exp_q.push_back(cur_blk[(j % N) * N + j / N]);
        cur_blk.delete();
      end
    end
    if (ordy && m_valid) begin
      void'(exp_q.pop_front());
      rd_cnt = (rd_cnt + 1) % NN;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_first", 32'(out_first), 32'd0);
    check_val("rst_out_last", 32'(out_last), 32'd0);
    @(negedge clk);
    check_val("rst_out_valid_hold", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    cur_blk.delete();
    exp_q.delete();
    rd_cnt = 0;
  endtask

  task automatic drain(input bit random_ready);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 2000) begin
      cycle(1'b0, random_ready ? 1'($urandom_range(0, 1)) : 1'b1, '0);
      b++;
    end
    cycle(1'b0, 1'b1, '0);
  endtask

  task automatic reset_counters();
    acc_cnt       = 0;
    dut_acc       = 0;
    dut_pops      = 0;
    dut_first_cyc = -1;
    dut_last_cyc  = -1;
  endtask

  initial begin
    int b;
    rd_cnt = 0;
    reset_counters();
    do_reset();

    // Single block 0..63 with the sink always ready.
    for (int i = 0; i < NN; i++) cycle(1'b1, 1'b1, DATA_W'(i));
    drain(1'b0);

    // Signed extremes at (0,1) and (1,0) pass through untouched.
    for (int i = 0; i < NN; i++)
      cycle(1'b1, 1'b1, (i == 1) ? 16'h8000 : (i == 8) ? 16'h7FFF : DATA_W'($urandom));
    drain(1'b0);

    // Back-pressure: sink stalled while three blocks are offered.
    reset_counters();
    for (int i = 0; i < 3 * NN + 16; i++) cycle(1'b1, 1'b0, DATA_W'($urandom));
    check_val("bp_accepts", 32'(dut_acc), 32'(2 * NN));
    b = 0;
    while (acc_cnt < 3 * NN && b < 1000) begin
      cycle(1'b1, 1'b1, DATA_W'($urandom));
      b++;
    end
    drain(1'b0);

    // Streaming: four blocks back to back, one output per cycle once started.
    reset_counters();
    b = 0;
    while (acc_cnt < 4 * NN && b < 1000) begin
      cycle(1'b1, 1'b1, DATA_W'($urandom));
      b++;
    end
    drain(1'b0);
    check_val("stream_outputs", 32'(dut_pops), 32'(4 * NN));
    check_val("stream_span", 32'(dut_last_cyc - dut_first_cyc), 32'(4 * NN - 1));

    // Random source and sink pacing.
    reset_counters();
    b = 0;
    while (acc_cnt < 5 * NN && b < 5000) begin
      cycle($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), DATA_W'($urandom));
      b++;
    end
    drain(1'b1);

    // Reset part-way through a block; only the following block may appear.
    reset_counters();
    for (int i = 0; i < 37; i++) cycle(1'b1, 1'b1, DATA_W'(16'hBEEF));
    do_reset();
    reset_counters();
    for (int i = 0; i < NN; i++) cycle(1'b1, 1'b1, DATA_W'(1000 + i));
    drain(1'b0);
    check_val("post_reset_outputs", 32'(dut_pops), 32'(NN));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
